serial_pattern_tx: RTL and testbench

//   Transmit end of the single-bit serial stream (w) consumed by the team's Moore/Mealy

---
 rtl/serial_pattern_tx_pkg.sv | 16 +
 rtl/serial_pattern_tx_shifter.sv | 46 ++++
 rtl/serial_pattern_tx.sv | 150 +++++++++++++++
 tb/tb_serial_pattern_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// State encoding and width helpers used by the top and the shifter.
package serial_pattern_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic int clog2m1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/serial_pattern_tx_shifter.sv
// Loadable pattern register with a down-counting bit index.
// Exposes the next bit, the first bit (for repeats) and a last flag.
module serial_pattern_tx_shifter #(
   parameter int MAX_LEN = 16,
   parameter int IW      = 4
) (
   input  logic               clk,
   input  logic               Resetn,
   input  logic               load,
   input  logic               reload,
   input  logic               adv,
   input  logic [MAX_LEN-1:0] din,
   input  logic [IW-1:0]      top,
   output logic               nbit,
   output logic               fbit,
   output logic               last
);

   logic [MAX_LEN-1:0] data_q;
   logic [IW-1:0]      top_q;
   logic [IW-1:0]      idx_q;
   logic [IW-1:0]      prev_idx;

   assign prev_idx = idx_q - IW'(1);
   assign nbit     = data_q[prev_idx];
   assign fbit     = data_q[top_q];
   assign last     = (idx_q == '0);

   // Pattern capture and index of the bit currently on the line
   always_ff @(posedge clk or negedge Resetn) begin
      if (!Resetn) begin
         data_q <= '0;
         top_q  <= '0;
         idx_q  <= '0;
      end else if (load) begin
         data_q <= din;
         top_q  <= top;
         idx_q  <= top;
      end else if (reload) begin
         idx_q  <= top_q;
      end else if (adv) begin
         idx_q  <= prev_idx;
      end
   end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: MSB-first bit stream with repeats and gaps.
// Feeds the w input of the sequence-detector FSMs.
module serial_pattern_tx
   import serial_pattern_tx_pkg::*;
#(
   parameter int   MAX_LEN    = 16,
   parameter int   GAP_CYCLES = 1,
   parameter logic IDLE_LEVEL = 1'b0,
   localparam int  LW         = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               Resetn,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [MAX_LEN-1:0] load_data,
   input  logic [LW-1:0]      load_len,
   input  logic [7:0]         repeat_cnt,
   input  logic               abort,
   output logic               w,
   output logic               w_valid,
   output logic               done
);

   localparam int IW = clog2m1(MAX_LEN);
   localparam int GW = clog2m1(GAP_CYCLES);

   state_e          state_q, state_d;
   logic            w_q, w_d;
   logic            wv_q, wv_d;
   logic            done_q, done_d;
   logic [7:0]      reps_q, reps_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [LW-1:0]   len_sat;
   logic [IW-1:0]   top_idx;
   logic            sh_load, sh_reload, sh_adv;
   logic            nbit, fbit, last;

   assign load_ready = (state_q == ST_IDLE) & ~abort;
   assign w          = w_q;
   assign w_valid    = wv_q;
   assign done       = done_q;

   assign len_sat = (load_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : load_len;
   assign top_idx = IW'(len_sat - LW'(1));

   serial_pattern_tx_shifter #(
      .MAX_LEN (MAX_LEN),
      .IW      (IW)
   ) u_shift (
      .clk    (clk),
      .Resetn (Resetn),
      .load   (sh_load),
      .reload (sh_reload),
      .adv    (sh_adv),
      .din    (load_data),
      .top    (top_idx),
      .nbit   (nbit),
      .fbit   (fbit),
      .last   (last)
   );

   // State, output and counter registers
   always_ff @(posedge clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         w_q     <= IDLE_LEVEL;
         wv_q    <= 1'b0;
         done_q  <= 1'b0;
         reps_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         wv_q    <= wv_d;
         done_q  <= done_d;
         reps_q  <= reps_d;
         gap_q   <= gap_d;
      end
   end

   // Next state, next registered outputs and shifter controls
   always_comb begin
      state_d   = state_q;
      w_d       = IDLE_LEVEL;
      wv_d      = 1'b0;
      done_d    = 1'b0;
      reps_d    = reps_q;
      gap_d     = gap_q;
      sh_load   = 1'b0;
      sh_reload = 1'b0;
      sh_adv    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (load_valid && load_ready) begin
               reps_d = repeat_cnt;
               if (len_sat == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_SHIFT;
                  w_d     = load_data[top_idx];
                  wv_d    = 1'b1;
                  sh_load = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!last) begin
               w_d    = nbit;
               wv_d   = 1'b1;
               sh_adv = 1'b1;
            end else if (reps_q != 8'd0) begin
               reps_d = reps_q - 8'd1;
               if (GAP_CYCLES > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GW'(GAP_CYCLES - 1);
               end else begin
                  w_d       = fbit;
                  wv_d      = 1'b1;
                  sh_reload = 1'b1;
               end
            end else begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (gap_q == '0) begin
               state_d   = ST_SHIFT;
               w_d       = fbit;
               wv_d      = 1'b1;
               sh_reload = 1'b1;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx.
// Vector table plus a per-cycle scoreboard and hand-written corner sequences.
module tb_serial_pattern_tx;

   localparam int MAX_LEN = 16;
   localparam int GAP     = 1;

   logic        clk = 1'b0;
   logic        Resetn;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [4:0]  load_len;
   logic [7:0]  repeat_cnt;
   logic        abort;
   logic        w;
   logic        w_valid;
   logic        done;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic vld;
      logic w;
      logic done;
   } obs_t;

   obs_t sbq[$];

   typedef struct {
      logic [15:0] data;
      logic [4:0]  len;
      logic [7:0]  rep;
      int          nvalid;
      int          ngap;
   } vec_t;

   vec_t vt[8];

   always #5 clk = ~clk;

   serial_pattern_tx #(
      .MAX_LEN    (MAX_LEN),
      .GAP_CYCLES (GAP),
      .IDLE_LEVEL (1'b0)
   ) dut (
      .clk        (clk),
      .Resetn     (Resetn),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .repeat_cnt (repeat_cnt),
      .abort      (abort),
      .w          (w),
      .w_valid    (w_valid),
      .done       (done)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected per-cycle stream, starting the cycle after the handshake
   task automatic push_exp(input logic [15:0] d, input logic [4:0] len,
                           input logic [7:0] rep);
      int l;
      l = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
      if (l == 0) begin
         sbq.push_back('{1'b0, 1'b0, 1'b1});
      end else begin
         for (int r = 0; r <= int'(rep); r++) begin
            for (int i = l - 1; i >= 0; i--)
               sbq.push_back('{1'b1, d[i], 1'b0});
            if (r < int'(rep))
               for (int g = 0; g < GAP; g++)
                  sbq.push_back('{1'b0, 1'b0, 1'b0});
         end
         sbq.push_back('{1'b0, 1'b0, 1'b1});
      end
   endtask

   task automatic handshake(input logic [15:0] d, input logic [4:0] len,
                            input logic [7:0] rep);
      int t;
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = d;
      load_len   = len;
      repeat_cnt = rep;
      t = 0;
      while (!load_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("hs_ready", {31'd0, load_ready}, 32'd1);
      @(posedge clk);
      push_exp(d, len, rep);
      #1;
      load_valid = 1'b0;
      load_data  = 16'hFFFF;
      load_len   = 5'd3;
      repeat_cnt = 8'd7;
   endtask

   task automatic drain(output int nv, output int ng);
      obs_t e;
      nv = 0;
      ng = 0;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         chk("stream", {29'd0, w_valid, w, done}, {29'd0, e});
         chk("busy_ready", {31'd0, load_ready}, 32'd0);
         if (w_valid) nv++;
         if (!w_valid && !done) ng++;
      end
      @(negedge clk);
      chk("post_done", {31'd0, done}, 32'd0);
      chk("post_ready", {31'd0, load_ready}, 32'd1);
   endtask

   initial begin
      int nv, ng, cyc, j, dcyc, f2, nd;
      logic [2:0]  hist;
      logic [15:0] zt;
      logic        bad;

      vt[0] = '{16'h000D, 5'd4,  8'd0,   4,   0};
      vt[1] = '{16'h0005, 5'd3,  8'd2,   9,   2};
      vt[2] = '{16'h1234, 5'd0,  8'd0,   0,   0};
      vt[3] = '{16'hABCD, 5'd16, 8'd0,   16,  0};
      vt[4] = '{16'hFFFF, 5'd20, 8'd0,   16,  0};
      vt[5] = '{16'h0001, 5'd1,  8'd3,   4,   3};
      vt[6] = '{16'h0002, 5'd2,  8'd1,   4,   1};
      vt[7] = '{16'h0001, 5'd1,  8'd255, 256, 255};

      Resetn     = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_len   = '0;
      repeat_cnt = '0;
      abort      = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_w", {31'd0, w}, 32'd0);
      chk("rst_wv", {31'd0, w_valid}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      Resetn = 1'b1;
      #1;
      chk("rst_ready", {31'd0, load_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         handshake(vt[i].data, vt[i].len, vt[i].rep);
         drain(nv, ng);
         chk("nvalid", nv, vt[i].nvalid);
         chk("ngap", ng, vt[i].ngap);
      end

      // abort in IDLE masks the handshake
      @(negedge clk);
      abort      = 1'b1;
      load_valid = 1'b1;
      load_data  = 16'h000F;
      load_len   = 5'd4;
      #1;
      chk("abort_idle_rdy", {31'd0, load_ready}, 32'd0);
      @(posedge clk);
      #1;
      abort      = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      chk("abort_idle_wv", {31'd0, w_valid}, 32'd0);
      chk("abort_idle_rdy2", {31'd0, load_ready}, 32'd1);

      // abort during the second bit of an 8-bit pattern
      handshake(16'h00A5, 5'd8, 8'd0);
      sbq.delete();
      @(negedge clk);
      chk("ab_bit1", {30'd0, w_valid, w}, 32'h3);
      @(negedge clk);
      chk("ab_bit2", {30'd0, w_valid, w}, 32'h2);
      abort = 1'b1;
      #1;
      chk("ab_rdy_mask", {31'd0, load_ready}, 32'd0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("ab_wv", {31'd0, w_valid}, 32'd0);
      chk("ab_rdy", {31'd0, load_ready}, 32'd1);
      bad = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done || w_valid) bad = 1'b1;
      end
      chk("ab_no_done", {31'd0, bad}, 32'd0);

      // detector driven back-to-back with load_valid held high
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 16'h006D;
      load_len   = 5'd8;
      repeat_cnt = 8'd0;
      cyc  = 0;
      j    = 0;
      dcyc = -100;
      f2   = -1;
      nd   = 0;
      hist = 3'b000;
      zt   = '0;
      while (cyc < 80 && nd < 2) begin
         @(negedge clk);
         cyc++;
         if (w_valid) begin
            hist = {hist[1:0], w};
            if (j < 16) zt[j] = (hist == 3'b101);
            if (j == 8) begin
               f2 = cyc;
               load_valid = 1'b0;
            end
            j++;
         end
         if (done) begin
            nd++;
            if (nd == 1) dcyc = cyc;
         end
      end
      load_valid = 1'b0;
      chk("det_z", {16'd0, zt}, 32'h9290);
      chk("det_bits", j, 16);
      chk("det_ndone", nd, 2);
      chk("det_gap", f2 - dcyc, 2);

      // reset asserted mid-SHIFT
      handshake(16'hABCD, 5'd16, 8'd0);
      sbq.delete();
      repeat (3) @(negedge clk);
      chk("mid_wv", {31'd0, w_valid}, 32'd1);
      Resetn = 1'b0;
      #1;
      chk("mid_rst_out", {29'd0, w_valid, w, done}, 32'd0);
      repeat (2) @(negedge clk);
      chk("mid_rst_hold", {29'd0, w_valid, w, done}, 32'd0);
      Resetn = 1'b1;
      #1;
      chk("mid_rst_rdy", {31'd0, load_ready}, 32'd1);
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || w_valid) bad = 1'b1;
      end
      chk("mid_rst_quiet", {31'd0, bad}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
